// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mem_resp_pkg;

    localparam int CNT_W          = 4;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DEPTH_LOG2 = 10;
    localparam int DEF_LATENCY    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word array; read data is registered on the access edge
// and a write returns the data being written.
module mem_resp_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Storage contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[idx];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder with stall/done handshake.
// Optional misaligned-address error reporting: MEM_RESP_ALIGN_ERR_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] resp_data,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    wr_q, misal_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       data_q;
    logic                    accept, access;
    logic                    acc_wr, acc_misal;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [DATA_W-1:0]       acc_data;
    logic                    done_q, zero_q;
    logic                    req_misal;
    logic [DATA_W-1:0]       arr_rdata;

`ifdef MEM_RESP_ALIGN_ERR_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[ADDR_W-1:DEPTH_LOG2+1];
    assign req_misal        = req_addr[0];
    assign err              = done_q & zero_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};
    assign req_misal        = 1'b0;
    assign err              = 1'b0;
`endif

    assign stall     = (state == BUSY);
    assign done      = done_q;
    assign resp_data = zero_q ? '0 : arr_rdata;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        acc_wr     = wr_q;
        acc_idx    = idx_q;
        acc_data   = data_q;
        acc_misal  = misal_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = CNT_LOAD;
                    if (LATENCY > 1) begin
                        state_next = BUSY;
                    end else begin
                        // Single-cycle latency: access straight from the request.
                        access    = 1'b1;
                        acc_wr    = req_wr;
                        acc_idx   = req_addr[DEPTH_LOG2:1];
                        acc_data  = req_data;
                        acc_misal = req_misal;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    access     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            wr_q    <= 1'b0;
            misal_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            done_q <= access;
            if (access) begin
                zero_q <= acc_misal;
            end
            if (accept) begin
                wr_q    <= req_wr;
                misal_q <= req_misal;
                idx_q   <= req_addr[DEPTH_LOG2:1];
                data_q  <= req_data;
            end
        end
    end

    mem_resp_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (access && !rst && !acc_misal),
        .we    (acc_wr),
        .idx   (acc_idx),
        .wdata (acc_data),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios then randomized
// requests, compared every cycle against a cycle-count reference model.
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic        stall, done, err;
    logic [15:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: word store, one outstanding request, expected responses.
    logic [15:0] mem_m [1024];
    logic [15:0] exp_q [$];
    logic [15:0] resp_m = '0;
    bit          pend = 1'b0;
    int          pend_done = 0;
    bit          pend_wr = 1'b0;
    bit          pend_mis = 1'b0;
    int          pend_idx = 0;
    logic [15:0] pend_data = '0;
    bit          acc_flag = 1'b0;
    int          pool_idx [8];

    always #5 clk = ~clk;

    mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .stall     (stall),
        .done      (done),
        .resp_data (resp_data),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input bit v, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input bit r);
        bit          exp_stall, exp_done, exp_err, mis;
        int          idx;
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        exp_stall = pend && (cyc < pend_done);
        exp_done  = pend && (cyc == pend_done);
        exp_err   = 1'b0;
        check("stall", 32'(stall), 32'(exp_stall));
        check("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            pend = 1'b0;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if (pend_wr && !pend_mis) mem_m[pend_idx] = pend_data;
            exp_err = pend_mis;
            resp_m  = e;
        end
        check("resp_data", 32'(resp_data), 32'(resp_m));
        check("err", 32'(err), 32'(exp_err));

        rst = r; req_valid = v; req_wr = w; req_addr = a; req_data = d;
        acc_flag = 1'b0;
        if (r) begin
            pend = 1'b0;
            exp_q.delete();
            resp_m = '0;
        end else if (v && !exp_stall) begin
            idx = int'(a[10:1]);
`ifdef MEM_RESP_ALIGN_ERR_EN
            mis = a[0];
`else
            mis = 1'b0;
`endif
            acc_flag  = 1'b1;
            pend      = 1'b1;
            pend_done = cyc + LAT;
            pend_wr   = w;
            pend_mis  = mis;
            pend_idx  = idx;
            pend_data = d;
            exp_q.push_back(mis ? 16'h0000 : (w ? d : mem_m[idx]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    // Present a request and hold it until the model says it was accepted.
    task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, w, a, d, 1'b0);
            if (acc_flag) break;
        end
        if (!acc_flag) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pend; i++) idle(1);
        check("drain_timeout", 32'(pend), 32'd0);
        idle(1);
    endtask

    initial begin
        logic [15:0] a;
        logic [9:0]  ix;
        logic [4:0]  hi;
        bit          lsb;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        idle(2);

        // Read latency, then back-to-back read issued during the write's done cycle.
        do_req(1'b1, 16'h0010, 16'hBEEF);
        do_req(1'b0, 16'h0010, 16'h0000);
        drain();
        do_req(1'b1, 16'h0002, 16'h1234);
        do_req(1'b0, 16'h0002, 16'h0000);
        drain();

        // Requests toggled while stalled must be ignored.
        do_req(1'b1, 16'h0020, 16'h0F0F);
        drain();
        do_req(1'b1, 16'h0004, 16'h1111);
        step(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
        step(1'b0, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
        step(1'b1, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
        drain();
        do_req(1'b0, 16'h0020, 16'h0000);
        drain();

        // Address wrap-around.
        do_req(1'b1, 16'h0802, 16'hA5A5);
        do_req(1'b0, 16'h0002, 16'h0000);
        drain();

        // Reset two cycles into a write: write must be lost.
        do_req(1'b1, 16'h0004, 16'h5555);
        idle(1);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        idle(2);
        do_req(1'b0, 16'h0004, 16'h0000);
        drain();

        // Odd address.
        do_req(1'b0, 16'h0003, 16'h0000);
        drain();

        // Randomized phase over a small pool of word indices.
        for (int i = 0; i < 8; i++) begin
            pool_idx[i] = $urandom_range(0, 1023);
            ix = 10'(pool_idx[i]);
            a  = {5'd0, ix, 1'b0};
            do_req(1'b1, a, 16'($urandom_range(0, 65535)));
        end
        drain();
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 2));
            ix  = 10'(pool_idx[$urandom_range(0, 7)]);
            hi  = 5'($urandom_range(0, 31));
            lsb = ($urandom_range(0, 3) == 0);
            a   = {hi, ix, lsb};
            do_req(1'($urandom_range(0, 1)), a, 16'($urandom_range(0, 65535)));
            for (int k = 0; k < 40 && pend; k++) begin
                step(($urandom_range(0, 3) == 0), 1'b1, 16'h0040, 16'hCAFE,
                     ($urandom_range(0, 29) == 0));
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
